vga_scan_gen: RTL and testbench

//   Raster timing source for the snake game. Produces the pixel coordinates (xCount, yCount),

---
 rtl/snake_vga_pkg.sv | 22 ++
 rtl/vga_scan_gen_scan_counter.sv | 40 ++++
 rtl/vga_scan_gen.sv | 152 +++++++++++++++
 tb/tb_vga_scan_gen.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_vga_pkg.sv
// Shared raster-timing constants and small typedefs for the snake game video and score logic.
package snake_vga_pkg;

    localparam int H_VISIBLE  = 640;
    localparam int H_FP       = 16;
    localparam int H_SYNC     = 96;
    localparam int H_BP       = 48;
    localparam int V_VISIBLE  = 480;
    localparam int V_FP       = 10;
    localparam int V_SYNC     = 2;
    localparam int V_BP       = 33;
    localparam int H_TOTAL    = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL    = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int BORDER_W   = 10;
    localparam int UPDATE_DIV = 5;
    localparam int COORD_W    = 10;
    localparam int DIV_W      = 6;

    typedef logic [6:0] colour_t;
    typedef logic [6:0] seg_t;

endpackage

// File: rtl/vga_scan_gen_scan_counter.sv
// Modulo-N counter with enable; wrap is high while the count sits at N-1 and en is asserted.
module scan_counter
    import snake_vga_pkg::*;
#(
    parameter int N = H_TOTAL,
    parameter int W = COORD_W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    output logic [W-1:0] o_count,
    output logic         o_wrap
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] r_count;
    logic         r_last;
    logic [W-1:0] w_next;

    assign w_next = (r_count == LAST) ? '0 : r_count + W'(1);

    // Count register plus a registered terminal-count flag so wrap needs no wide compare.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
            r_last  <= (LAST == '0);
        end else if (i_en) begin
            r_count <= w_next;
            r_last  <= (w_next == LAST);
        end else begin
            r_count <= r_count;
            r_last  <= r_last;
        end
    end

    assign o_count = r_count;
    assign o_wrap  = r_last & i_en;

endmodule

// File: rtl/vga_scan_gen.sv
// Raster timing source: coordinates, syncs, visible/border flags, frame_done and the game tick.
// Build macro SCAN_SYNC_PIPE_EN delays hsync, vsync and displayArea by two extra clocks.
module vga_scan_gen
    import snake_vga_pkg::*;
#(
    parameter int P_H_VISIBLE  = H_VISIBLE,
    parameter int P_H_FP       = H_FP,
    parameter int P_H_SYNC     = H_SYNC,
    parameter int P_H_BP       = H_BP,
    parameter int P_V_VISIBLE  = V_VISIBLE,
    parameter int P_V_FP       = V_FP,
    parameter int P_V_SYNC     = V_SYNC,
    parameter int P_V_BP       = V_BP,
    parameter int P_BORDER_W   = BORDER_W,
    parameter int P_UPDATE_DIV = UPDATE_DIV
) (
    input  logic               VGA_clk,
    input  logic               reset,
    output logic [COORD_W-1:0] xCount,
    output logic [COORD_W-1:0] yCount,
    output logic               hsync,
    output logic               vsync,
    output logic               displayArea,
    output logic               border,
    output logic               update,
    output logic               frame_done
);

    localparam int H_TOT = P_H_VISIBLE + P_H_FP + P_H_SYNC + P_H_BP;
    localparam int V_TOT = P_V_VISIBLE + P_V_FP + P_V_SYNC + P_V_BP;

    localparam logic [COORD_W-1:0] X_VIS    = COORD_W'(P_H_VISIBLE);
    localparam logic [COORD_W-1:0] Y_VIS    = COORD_W'(P_V_VISIBLE);
    localparam logic [COORD_W-1:0] X_HS_ON  = COORD_W'(P_H_VISIBLE + P_H_FP);
    localparam logic [COORD_W-1:0] X_HS_OFF = COORD_W'(P_H_VISIBLE + P_H_FP + P_H_SYNC);
    localparam logic [COORD_W-1:0] Y_VS_ON  = COORD_W'(P_V_VISIBLE + P_V_FP);
    localparam logic [COORD_W-1:0] Y_VS_OFF = COORD_W'(P_V_VISIBLE + P_V_FP + P_V_SYNC);
    localparam logic [COORD_W-1:0] X_BL     = COORD_W'(P_BORDER_W);
    localparam logic [COORD_W-1:0] X_BR     = COORD_W'(P_H_VISIBLE - P_BORDER_W);
    localparam logic [COORD_W-1:0] Y_BT     = COORD_W'(P_BORDER_W);
    localparam logic [COORD_W-1:0] Y_BB     = COORD_W'(P_V_VISIBLE - P_BORDER_W);
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(P_UPDATE_DIV - 1);

    // The counters run one clock ahead of the outputs so every flag can be registered aligned.
    logic [COORD_W-1:0] w_x;
    logic [COORD_W-1:0] w_y;
    logic [DIV_W-1:0]   w_div;
    logic               w_x_wrap;
    logic               w_frame_end;
    logic               w_div_wrap_unused;
    logic               w_disp;
    logic               w_hs;
    logic               w_vs;
    logic               w_border;
    logic               w_update;

    scan_counter #(.N(H_TOT), .W(COORD_W)) u_x_cnt (
        .i_clk   (VGA_clk),
        .i_rst   (reset),
        .i_en    (1'b1),
        .o_count (w_x),
        .o_wrap  (w_x_wrap)
    );

    scan_counter #(.N(V_TOT), .W(COORD_W)) u_y_cnt (
        .i_clk   (VGA_clk),
        .i_rst   (reset),
        .i_en    (w_x_wrap),
        .o_count (w_y),
        .o_wrap  (w_frame_end)
    );

    scan_counter #(.N(P_UPDATE_DIV), .W(DIV_W)) u_div_cnt (
        .i_clk   (VGA_clk),
        .i_rst   (reset),
        .i_en    (w_frame_end),
        .o_count (w_div),
        .o_wrap  (w_div_wrap_unused)
    );

    assign w_disp   = (w_x < X_VIS) && (w_y < Y_VIS);
    assign w_hs     = !((w_x >= X_HS_ON) && (w_x < X_HS_OFF));
    assign w_vs     = !((w_y >= Y_VS_ON) && (w_y < Y_VS_OFF));
    assign w_border = w_disp && ((w_x < X_BL) || (w_x >= X_BR) || (w_y < Y_BT) || (w_y >= Y_BB));
    assign w_update = (w_x == '0) && (w_y == Y_VIS) && (w_div == DIV_LAST);

    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic               r_hs;
    logic               r_vs;
    logic               r_disp;
    logic               r_border;
    logic               r_update;
    logic               r_frame_done;

    // Output stage: present the coordinate and all of its decoded flags on the same clock.
    always_ff @(posedge VGA_clk or posedge reset) begin
        if (reset) begin
            r_x          <= '0;
            r_y          <= '0;
            r_hs         <= 1'b1;
            r_vs         <= 1'b1;
            r_disp       <= 1'b0;
            r_border     <= 1'b0;
            r_update     <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_x          <= w_x;
            r_y          <= w_y;
            r_hs         <= w_hs;
            r_vs         <= w_vs;
            r_disp       <= w_disp;
            r_border     <= w_border;
            r_update     <= w_update;
            r_frame_done <= w_frame_end;
        end
    end

`ifdef SCAN_SYNC_PIPE_EN
    logic [1:0] r_hs_pipe;
    logic [1:0] r_vs_pipe;
    logic [1:0] r_disp_pipe;

    // Delay the monitor-facing strobes to line up with the two-stage pixel colour path.
    always_ff @(posedge VGA_clk or posedge reset) begin
        if (reset) begin
            r_hs_pipe   <= 2'b11;
            r_vs_pipe   <= 2'b11;
            r_disp_pipe <= 2'b00;
        end else begin
            r_hs_pipe   <= {r_hs_pipe[0], r_hs};
            r_vs_pipe   <= {r_vs_pipe[0], r_vs};
            r_disp_pipe <= {r_disp_pipe[0], r_disp};
        end
    end

    assign hsync       = r_hs_pipe[1];
    assign vsync       = r_vs_pipe[1];
    assign displayArea = r_disp_pipe[1];
`else
    assign hsync       = r_hs;
    assign vsync       = r_vs;
    assign displayArea = r_disp;
`endif

    assign xCount     = r_x;
    assign yCount     = r_y;
    assign border     = r_border;
    assign update     = r_update;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Self-checking bench: small-raster DUT against a per-clock scoreboard, plus a full-size instance.
module tb_vga_scan_gen;
    import snake_vga_pkg::*;

    localparam int HV = 40, HFP = 4, HS = 6, HBP = 6;
    localparam int VV = 24, VFP = 2, VS = 2, VBP = 4;
    localparam int BW = 3, DIV = 5;
    localparam int HT = HV + HFP + HS + HBP;
    localparam int VT = VV + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
`ifdef SCAN_SYNC_PIPE_EN
    localparam int PIPE = 2;
`else
    localparam int PIPE = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [9:0] xCount, yCount;
    logic hsync, vsync, displayArea, border, update, frame_done;
    logic [9:0] unused_d1_x, unused_d1_y;
    logic unused_d1_hs, unused_d1_vs, unused_d1_da, unused_d1_bd, unused_d1_fd, d1_update;
    logic [9:0] def_x, def_y;
    logic def_hs, def_border, unused_def_vs, unused_def_da, unused_def_up, unused_def_fd;

    vga_scan_gen #(
        .P_H_VISIBLE(HV), .P_H_FP(HFP), .P_H_SYNC(HS), .P_H_BP(HBP),
        .P_V_VISIBLE(VV), .P_V_FP(VFP), .P_V_SYNC(VS), .P_V_BP(VBP),
        .P_BORDER_W(BW), .P_UPDATE_DIV(DIV)
    ) u_dut (
        .VGA_clk(clk), .reset(rst), .xCount(xCount), .yCount(yCount),
        .hsync(hsync), .vsync(vsync), .displayArea(displayArea), .border(border),
        .update(update), .frame_done(frame_done)
    );

    vga_scan_gen #(
        .P_H_VISIBLE(HV), .P_H_FP(HFP), .P_H_SYNC(HS), .P_H_BP(HBP),
        .P_V_VISIBLE(VV), .P_V_FP(VFP), .P_V_SYNC(VS), .P_V_BP(VBP),
        .P_BORDER_W(BW), .P_UPDATE_DIV(1)
    ) u_div1 (
        .VGA_clk(clk), .reset(rst), .xCount(unused_d1_x), .yCount(unused_d1_y),
        .hsync(unused_d1_hs), .vsync(unused_d1_vs), .displayArea(unused_d1_da),
        .border(unused_d1_bd), .update(d1_update), .frame_done(unused_d1_fd)
    );

    vga_scan_gen u_def (
        .VGA_clk(clk), .reset(rst), .xCount(def_x), .yCount(def_y),
        .hsync(def_hs), .vsync(unused_def_vs), .displayArea(unused_def_da),
        .border(def_border), .update(unused_def_up), .frame_done(unused_def_fd)
    );

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [5:0] fl;
    } exp_t;

    exp_t sb[$];
    int   up_frames[$];
    int   checks = 0, errors = 0, ticks = 0;
    int   fd_count = 0, last_fd = -1, first_fd = -1, intervals = 0, bad_int = 0;
    int   d1_ups = 0, def_low0 = 0, def_first_low = -1;
    bit   def_mon = 1'b0;
    logic [3:0] def_b = 4'bxxxx;

    bit   m_started = 1'b0;
    int   mx = 0, my = 0, m_frames = 0;
    logic [2:0] m_p0 = 3'b110, m_p1 = 3'b110;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: advance the expected raster position and push its expected outputs.
    task automatic model_step();
        logic hs, vs, da, bd, up, fd;
        exp_t e;
        if (!m_started) begin
            m_started = 1'b1;
            mx = 0;
            my = 0;
        end else if (mx == HT - 1) begin
            mx = 0;
            my = (my == VT - 1) ? 0 : my + 1;
        end else begin
            mx = mx + 1;
        end
        da = (mx < HV) && (my < VV);
        hs = !((mx >= HV + HFP) && (mx < HV + HFP + HS));
        vs = !((my >= VV + VFP) && (my < VV + VFP + VS));
        bd = da && ((mx < BW) || (mx >= HV - BW) || (my < BW) || (my >= VV - BW));
        fd = (mx == HT - 1) && (my == VT - 1);
        up = (mx == 0) && (my == VV) && ((m_frames % DIV) == DIV - 1);
        if (fd) m_frames++;
`ifdef SCAN_SYNC_PIPE_EN
        begin : pipe_model
            logic [2:0] dly;
            dly = m_p1;
            m_p1 = m_p0;
            m_p0 = {hs, vs, da};
            {hs, vs, da} = dly;
        end
`endif
        e.x  = 10'(mx);
        e.y  = 10'(my);
        e.fl = {hs, vs, da, bd, up, fd};
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        model_step();
        #1;
        ticks++;
        e = sb.pop_front();
        chk($sformatf("coord@%0d", ticks), 32'({xCount, yCount}), 32'({e.x, e.y}));
        chk($sformatf("flags@(%0d,%0d)", e.x, e.y),
            32'({hsync, vsync, displayArea, border, update, frame_done}), 32'(e.fl));
        if (frame_done) begin
            if (last_fd >= 0) begin
                intervals++;
                if (ticks - last_fd != FRAME) bad_int++;
            end else begin
                first_fd = ticks;
            end
            last_fd = ticks;
            fd_count++;
        end
        if (update) up_frames.push_back(fd_count + 1);
        if (d1_update) d1_ups++;
        if (def_mon) begin
            if (def_y == 10'd0 && !def_hs) begin
                def_low0++;
                if (def_first_low < 0) def_first_low = int'(def_x);
            end
            if (def_y == 10'd10) begin
                if (def_x == 10'd9)   def_b[0] = def_border;
                if (def_x == 10'd10)  def_b[1] = def_border;
                if (def_x == 10'd629) def_b[2] = def_border;
                if (def_x == 10'd630) def_b[3] = def_border;
            end
        end
    endtask

    task automatic run_to(input int tx, input int ty);
        int n;
        n = 0;
        while (!(xCount == 10'(tx) && yCount == 10'(ty)) && n < 2 * FRAME) begin
            tick();
            n++;
        end
        chk($sformatf("reach(%0d,%0d)", tx, ty), 32'({xCount, yCount}), 32'({10'(tx), 10'(ty)}));
    endtask

    int   bx[7]   = '{3, 45, BW - 1, HV - BW, HV - BW - 1, 20, 5};
    int   by[7]   = '{3, 5, 12, 12, VV - BW - 1, VV - BW, 27};
    logic bexp[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        int guard;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_coord", 32'({xCount, yCount}), 32'd0);
        chk("rst_flags", 32'({hsync, vsync, displayArea, border, update, frame_done}), 32'(6'b110000));
        @(negedge clk);
        rst = 1'b0;
        ticks = 0;
        def_mon = 1'b1;

        tick();
        chk("first_x", 32'(xCount), 32'd0);
        chk("first_da", 32'(displayArea), (PIPE == 0) ? 32'd1 : 32'd0);
        chk("first_border", 32'(border), 32'd1);
        tick();
        chk("second_x", 32'(xCount), 32'd1);

        for (int i = 0; i < 7; i++) begin
            run_to(bx[i], by[i]);
            chk($sformatf("border(%0d,%0d)", bx[i], by[i]), 32'(border), 32'(bexp[i]));
        end

        guard = 0;
        while (fd_count < 12 && guard < 13 * FRAME) begin
            tick();
            guard++;
        end
        chk("frames12", 32'(fd_count), 32'd12);
        chk("first_fd_tick", 32'(first_fd), 32'(FRAME));
        chk("fd_intervals", 32'(intervals), 32'd11);
        chk("fd_bad_intervals", 32'(bad_int), 32'd0);
        chk("update_count", 32'(up_frames.size()), 32'd2);
        chk("update_frame_a", (up_frames.size() > 0) ? 32'(up_frames[0]) : 32'hffff_ffff, 32'd5);
        chk("update_frame_b", (up_frames.size() > 1) ? 32'(up_frames[1]) : 32'hffff_ffff, 32'd10);
        chk("div1_updates", 32'(d1_ups), 32'd12);
        chk("def_hsync_start", 32'(def_first_low), 32'(656 + PIPE));
        chk("def_hsync_width", 32'(def_low0), 32'd96);
        chk("def_border_row10", 32'(def_b), 32'(4'b1001));
        def_mon = 1'b0;

        run_to(28, 15);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_coord", 32'({xCount, yCount}), 32'd0);
        chk("mid_rst_flags", 32'({hsync, vsync, displayArea, border, update, frame_done}), 32'(6'b110000));
        sb.delete();
        up_frames.delete();
        m_started = 1'b0;
        m_frames = 0;
        m_p0 = 3'b110;
        m_p1 = 3'b110;
        fd_count = 0;
        last_fd = -1;
        first_fd = -1;
        intervals = 0;
        bad_int = 0;
        @(negedge clk);
        rst = 1'b0;
        ticks = 0;

        guard = 0;
        while (fd_count < 5 && guard < 6 * FRAME) begin
            tick();
            guard++;
        end
        chk("post_rst_frames", 32'(fd_count), 32'd5);
        chk("post_rst_first_fd", 32'(first_fd), 32'(FRAME));
        chk("post_rst_updates", 32'(up_frames.size()), 32'd1);
        chk("post_rst_update_frame", (up_frames.size() > 0) ? 32'(up_frames[0]) : 32'hffff_ffff, 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
